// File: rtl/req_arbiter8_pkg.sv
// Shared encodings for the 8-way active-low request arbiter.
// Holds the FSM state type and the "no grant" output constants.
package req_arbiter8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] NO_GNT   = 8'hFF;
    localparam logic [2:0] IDX_NONE = 3'b111;

    // Active-low one-hot grant for a given owner index.
    function automatic logic [7:0] gnt_from_idx(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/req_arbiter8_pick.sv
// Combinational winner selection: rotate the request vector so the search
// starts below the pointer, take the highest active bit, then rotate back.
module req_pri_pick8
    import req_arbiter8_pkg::*;
(
    input  logic [7:0] req_n,
    input  logic [2:0] start,
    input  logic       mode,
    output logic [2:0] win_idx,
    output logic       any_req
);

    logic [2:0]  base;
    logic [7:0]  act;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;

    always_comb begin
        // Fixed priority is round-robin with the pointer pinned at 0.
        base    = mode ? start : 3'd0;
        act     = ~req_n;
        dbl     = {act, act} >> base;
        rot     = dbl[7:0];
        any_req = |act;
        off     = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (rot[j]) begin
                off = 3'(j);
            end
        end
        win_idx = off + base;
    end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester arbiter: registered grant held until release, withdrawal
// or hold timeout, followed by one RELEASE cycle before re-arbitrating.
module req_arbiter8
    import req_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEI,
    input  logic       iMode,
    input  logic [7:0] iReq,
    input  logic       iDone,
    output logic [7:0] oGnt,
    output logic [2:0] oIdx,
    output logic       oValid,
    output logic       oBusy,
    output logic       oTimeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [2:0] win_idx;
    logic       any_req;
    logic       withdraw;
    logic       hold_exp;

    req_pri_pick8 u_pick (
        .req_n   (iReq),
        .start   (ptr_q),
        .mode    (iMode),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        withdraw  = iReq[idx_q];
        hold_exp  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                gnt_d   = NO_GNT;
                idx_d   = IDX_NONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (!iEI && any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = gnt_from_idx(win_idx);
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (iDone || withdraw || hold_exp) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = NO_GNT;
                    idx_d     = IDX_NONE;
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                    ptr_d     = idx_q;
                    // A voluntary release in the same cycle suppresses the timeout flag.
                    timeout_d = hold_exp && !iDone && !withdraw;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = NO_GNT;
                idx_d   = IDX_NONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= 3'd0;
            gnt_q     <= NO_GNT;
            idx_q     <= IDX_NONE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign oGnt     = gnt_q;
    assign oIdx     = idx_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: a transaction-level model predicts the
// outputs after every clock edge; a monitor compares them one cycle later.
module tb_req_arbiter8;

    localparam int MAX_HOLD = 15;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iEI = 1'b1;
    logic       iMode = 1'b0;
    logic [7:0] iReq = 8'hFF;
    logic       iDone = 1'b0;
    logic [7:0] oGnt;
    logic [2:0] oIdx;
    logic       oValid;
    logic       oBusy;
    logic       oTimeout;

    req_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEI      (iEI),
        .iMode    (iMode),
        .iReq     (iReq),
        .iDone    (iDone),
        .oGnt     (oGnt),
        .oIdx     (oIdx),
        .oValid   (oValid),
        .oBusy    (oBusy),
        .oTimeout (oTimeout)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: who owns the resource, how long, and whether the
    // mandatory idle gap after a release is still pending.
    int m_owner = -1;
    int m_age   = 0;
    int m_last  = 0;
    bit m_gap   = 1'b0;
    int n_timeouts = 0;
    int n_grants   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic int pick(input logic [7:0] req, input bit mode);
        int s;
        s = mode ? m_last : 0;
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (s - k + 16) % 8;
            if (req[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit ei, input bit mode,
                              input logic [7:0] req, input bit done, output exp_t e);
        e = '{gnt: 8'hFF, idx: 3'b111, valid: 1'b0, busy: 1'b0, to: 1'b0};
        if (rst) begin
            m_owner = -1; m_age = 0; m_last = 0; m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            bit wd, tmo;
            wd  = req[m_owner];
            tmo = (MAX_HOLD != 0) && (m_age == MAX_HOLD - 1);
            if (done || wd || tmo) begin
                e.busy = 1'b1;
                e.to   = tmo && !done && !wd;
                if (e.to) n_timeouts++;
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_age++;
                e.gnt = ~(8'd1 << m_owner); e.idx = 3'(m_owner);
                e.valid = 1'b1; e.busy = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (!ei && req != 8'hFF) begin
            m_owner = pick(req, mode);
            m_age   = 0;
            n_grants++;
            e.gnt = ~(8'd1 << m_owner); e.idx = 3'(m_owner);
            e.valid = 1'b1; e.busy = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit ei, input bit mode,
                        input logic [7:0] req, input bit done);
        exp_t e;
        @(negedge iClk);
        iRst = rst; iEI = ei; iMode = mode; iReq = req; iDone = done;
        model_step(rst, ei, mode, req, done, e);
        sb_q.push_back(e);
    endtask

    // Monitor: one expected record per clock edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge iClk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("oGnt",     int'(oGnt),     int'(e.gnt));
                check("oIdx",     int'(oIdx),     int'(e.idx));
                check("oValid",   int'(oValid),   int'(e.valid));
                check("oBusy",    int'(oBusy),    int'(e.busy));
                check("oTimeout", int'(oTimeout), int'(e.to));
                check("gnt_onehot0", int'($countones(~oGnt) <= 1), 1);
                check("valid_vs_gnt", int'(oValid), int'(oGnt != 8'hFF));
                if (oValid) check("idx_vs_gnt", int'(oGnt[oIdx]), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (got running, expected finished)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        bit ei, md, dn, rs;

        step(1, 1, 0, 8'hFF, 0);
        step(1, 1, 0, 8'hFF, 0);

        // Fixed priority with 6 and 4 requesting; release then re-grant 6.
        for (int c = 0; c < 8; c++) step(0, 0, 0, 8'b1010_1111, c == 4);

        // Round-robin with everyone requesting and immediate release.
        for (int c = 0; c < 30; c++) step(0, 0, 1, 8'h00, 1);

        // Hold timeout, then release coinciding with the last allowed cycle.
        for (int c = 0; c < 40; c++) step(0, 0, 0, 8'b1111_1110, 0);
        for (int c = 0; c < 40; c++)
            step(0, 0, 0, 8'b1111_1110, (m_owner >= 0) && (m_age == MAX_HOLD - 1));

        // Enable blocks new grants but not an existing one.
        for (int c = 0; c < 4; c++) step(0, 0, 0, 8'hFF, 1);
        for (int c = 0; c < 20; c++) step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        for (int c = 0; c < 6; c++) step(0, 1, 0, 8'h00, 0);
        for (int c = 0; c < 3; c++) step(0, 1, 0, 8'h00, 1);

        // Owner 3 withdraws while 5 is requesting.
        for (int c = 0; c < 3; c++) step(0, 0, 0, 8'hFF, 1);
        for (int c = 0; c < 3; c++) step(0, 0, 0, 8'b1111_0111, 0);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 8'b1101_1111, 0);

        // Reset during a round-robin grant resets the pointer.
        for (int c = 0; c < 10; c++) step(0, 0, 1, 8'h00, c % 2);
        step(1, 0, 1, 8'h00, 0);
        for (int c = 0; c < 6; c++) step(0, 0, 1, 8'h00, 0);

        // Randomized traffic.
        r = 8'h00; md = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 5) == 0) r = 8'($urandom) | 8'($urandom);
            if ($urandom_range(0, 40) == 0) md = ~md;
            ei = ($urandom_range(0, 7) == 0);
            dn = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(rs, ei, md, r, dn);
        end

        @(posedge iClk);
        @(posedge iClk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        check("saw_timeouts", int'(n_timeouts > 0), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
